// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Optional lock feature in the arbiter is enabled by defining ALU_ARB_LOCK_EN.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    typedef logic req_idx_t;

    // Low nibbles of FunSel codes whose result depends on the shared C flag.
    localparam logic [3:0] FS_LO_ADC = 4'b0101;
    localparam logic [3:0] FS_LO_CSL = 4'b1110;
    localparam logic [3:0] FS_LO_CSR = 4'b1111;

    function automatic logic is_carry_op(input logic [4:0] fs);
        return (fs[3:0] == FS_LO_ADC) || (fs[3:0] == FS_LO_CSL) ||
               (fs[3:0] == FS_LO_CSR);
    endfunction

endpackage

// File: rtl/alu_arb_rr2.sv
// Two-way round-robin pick: a valid lock owner that is requesting wins outright,
// otherwise the priority pointer breaks a tie and a lone requester always wins.
module alu_arb_rr2
    import alu_arb_pkg::*;
(
    input  logic [1:0] Req,
    input  req_idx_t   prio,
    input  req_idx_t   lock_owner,
    input  logic       lock_vld,
    output logic [1:0] Gnt,
    output req_idx_t   winner
);

    always_comb begin
        winner = prio;
        if (lock_vld && Req[lock_owner]) begin
            winner = lock_owner;
        end else if (Req == 2'b11) begin
            winner = prio;
        end else begin
            winner = req_idx_t'(Req[1]);
        end

        Gnt = 2'b00;
        if (|Req) begin
            Gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: IDLE grants and latches operands, ISSUE
// drives the ALU (flags write only here), DONE pulses Done. Lock via ALU_ARB_LOCK_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DEFAULT_PRIO = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  Req,
    input  logic [31:0] ReqA0,
    input  logic [31:0] ReqB0,
    input  logic [31:0] ReqA1,
    input  logic [31:0] ReqB1,
    input  logic [4:0]  ReqFunSel0,
    input  logic [4:0]  ReqFunSel1,
    input  logic [1:0]  ReqWF,
`ifdef ALU_ARB_LOCK_EN
    input  logic [1:0]  Lock,
`endif
    output logic [1:0]  Gnt,
    output logic [1:0]  Done,
    output logic [31:0] Result,
    output logic [3:0]  Flags,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [31:0] AluOut,
    input  logic [3:0]  AluFlags
);

    localparam req_idx_t PRIO_RST = (DEFAULT_PRIO != 0) ? 1'b1 : 1'b0;

    arb_state_e  state_q;
    req_idx_t    prio_q;
    req_idx_t    winner_q;
    req_idx_t    lock_owner_q;
    logic        lock_vld_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  fs_q;
    logic        wf_q;
    logic [1:0]  done_q;
    logic [31:0] result_q;

    logic [1:0]  rr_gnt;
    req_idx_t    rr_winner;

    alu_arb_rr2 u_rr2 (
        .Req        (Req),
        .prio       (prio_q),
        .lock_owner (lock_owner_q),
        .lock_vld   (lock_vld_q),
        .Gnt        (rr_gnt),
        .winner     (rr_winner)
    );

    // Grant is only offered while IDLE; requests seen in ISSUE/DONE wait.
    assign Gnt       = (state_q == ST_IDLE) ? rr_gnt : 2'b00;
    assign Done      = done_q;
    assign Result    = result_q;
    assign Flags     = AluFlags;
    assign AluA      = a_q;
    assign AluB      = b_q;
    assign AluFunSel = fs_q;
    assign AluWF     = wf_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            prio_q       <= PRIO_RST;
            winner_q     <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_vld_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            fs_q         <= '0;
            wf_q         <= 1'b0;
            done_q       <= 2'b00;
            result_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|Req) begin
                        winner_q <= rr_winner;
                        a_q      <= rr_winner ? ReqA1 : ReqA0;
                        b_q      <= rr_winner ? ReqB1 : ReqB0;
                        fs_q     <= rr_winner ? ReqFunSel1 : ReqFunSel0;
                        wf_q     <= ReqWF[rr_winner];
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    result_q <= AluOut;
                    wf_q     <= 1'b0;
                    done_q   <= 2'b01 << winner_q;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 2'b00;
                    state_q <= ST_IDLE;
`ifdef ALU_ARB_LOCK_EN
                    // A locked owner keeps the pointer so a carry chain stays contiguous.
                    if (Lock[winner_q]) begin
                        lock_vld_q   <= 1'b1;
                        lock_owner_q <= winner_q;
                    end else begin
                        lock_vld_q <= 1'b0;
                        prio_q     <= ~prio_q;
                    end
`else
                    prio_q <= ~prio_q;
`endif
                end
                default: begin
                    wf_q    <= 1'b0;
                    done_q  <= 2'b00;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge Clock) disable iff (!Reset)
        $onehot0(Gnt));

    a_done_onehot: assert property (@(posedge Clock) disable iff (!Reset)
        $onehot0(Done));

    a_wf_only_issue: assert property (@(posedge Clock) disable iff (!Reset)
        AluWF |-> (state_q == ST_ISSUE));

    // The carry-in consumed by ADC/CSL/CSR must not have been rewritten the cycle before.
    a_carry_stable: assert property (@(posedge Clock) disable iff (!Reset)
        ((state_q == ST_ISSUE) && is_carry_op(AluFunSel)) |-> !$past(AluWF));

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and transaction model.
module tb_alu_arbiter;

    logic        Clock;
    logic        Reset;
    logic [1:0]  Req;
    logic [31:0] ReqA0, ReqB0, ReqA1, ReqB1;
    logic [4:0]  ReqFunSel0, ReqFunSel1;
    logic [1:0]  ReqWF;
    logic [1:0]  lock_b;
    logic [1:0]  Gnt, Done;
    logic [31:0] Result;
    logic [3:0]  Flags;
    logic [31:0] AluA, AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [31:0] AluOut;
    logic [3:0]  AluFlags;

    int n_cmp = 0;
    int n_err = 0;

    logic       m_prio = 1'b0;
    logic       m_lock_vld = 1'b0;
    logic       m_lock_owner = 1'b0;
    logic [3:0] m_flags = 4'b0000;

    alu_arbiter #(.DEFAULT_PRIO(0)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req        (Req),
        .ReqA0      (ReqA0),
        .ReqB0      (ReqB0),
        .ReqA1      (ReqA1),
        .ReqB1      (ReqB1),
        .ReqFunSel0 (ReqFunSel0),
        .ReqFunSel1 (ReqFunSel1),
        .ReqWF      (ReqWF),
`ifdef ALU_ARB_LOCK_EN
        .Lock       (lock_b),
`endif
        .Gnt        (Gnt),
        .Done       (Done),
        .Result     (Result),
        .Flags      (Flags),
        .AluA       (AluA),
        .AluB       (AluB),
        .AluFunSel  (AluFunSel),
        .AluWF      (AluWF),
        .AluOut     (AluOut),
        .AluFlags   (AluFlags)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Behavioural ALU: combinational result, flags written on the edge when WF is high.
    logic [3:0]  alu_flags_q = 4'b0000;
    logic [3:0]  alu_nf;
    logic [32:0] s33;
    logic [31:0] bop;
    logic        arith;

    always_comb begin
        bop   = AluB;
        s33   = '0;
        arith = 1'b1;
        case (AluFunSel[3:0])
            4'b0100: s33 = {1'b0, AluA} + {1'b0, AluB};
            4'b0101: s33 = {1'b0, AluA} + {1'b0, AluB} + {32'd0, alu_flags_q[2]};
            4'b0110: begin
                bop = ~AluB;
                s33 = {1'b0, AluA} + {1'b0, bop} + 33'd1;
            end
            default: begin
                s33   = {1'b0, AluA & AluB};
                arith = 1'b0;
            end
        endcase
        AluOut    = s33[31:0];
        alu_nf[3] = (s33[31:0] == 32'd0);
        alu_nf[1] = s33[31];
        alu_nf[2] = arith ? s33[32] : alu_flags_q[2];
        alu_nf[0] = arith ? ((AluA[31] == bop[31]) && (s33[31] != AluA[31])) : alu_flags_q[0];
    end

    always @(posedge Clock) begin
        if (AluWF) alu_flags_q <= alu_nf;
    end
    assign AluFlags = alu_flags_q;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic in wide signed/unsigned integers.
    task automatic ref_op(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] fin, output logic [31:0] r, output logic [3:0] fo);
        longint ua, ub, sa, sb, u, s;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = $signed(a);
        sb = $signed(b);
        fo = fin;
        case (fs[3:0])
            4'b0100, 4'b0101: begin
                u = ua + ub + ((fs[3:0] == 4'b0101) ? longint'(fin[2]) : 64'sd0);
                s = sa + sb + ((fs[3:0] == 4'b0101) ? longint'(fin[2]) : 64'sd0);
                r = u[31:0];
                fo[2] = (u > 64'sh0FFFFFFFF);
                fo[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                u = ua - ub;
                s = sa - sb;
                r = u[31:0];
                fo[2] = (ua >= ub);
                fo[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: r = a & b;
        endcase
        fo[3] = (r == 32'd0);
        fo[1] = r[31];
    endtask

    task automatic run_txn(input logic [1:0] rq, input string tag);
        logic        w, wfw;
        logic [31:0] a, b, r;
        logic [4:0]  fs;
        logic [3:0]  fo;
        @(negedge Clock);
        Req = rq;
        #1;
        if (m_lock_vld && rq[m_lock_owner]) w = m_lock_owner;
        else if (rq == 2'b11)               w = m_prio;
        else                                w = rq[1];
        chk({tag, "_gnt"}, 64'(Gnt), 64'(2'b01 << w));
        a   = w ? ReqA1 : ReqA0;
        b   = w ? ReqB1 : ReqB0;
        fs  = w ? ReqFunSel1 : ReqFunSel0;
        wfw = ReqWF[w];
        @(posedge Clock); #1;
        Req = 2'b00;
        chk({tag, "_iss_wf"}, 64'(AluWF), 64'(wfw));
        chk({tag, "_iss_fs"}, 64'(AluFunSel), 64'(fs));
        chk({tag, "_iss_a"}, 64'(AluA), 64'(a));
        chk({tag, "_iss_b"}, 64'(AluB), 64'(b));
        ref_op(fs, a, b, m_flags, r, fo);
        if (wfw) m_flags = fo;
        @(posedge Clock); #1;
        chk({tag, "_done"}, 64'(Done), 64'(2'b01 << w));
        chk({tag, "_res"}, 64'(Result), 64'(r));
        chk({tag, "_flg"}, 64'(Flags), 64'(m_flags));
        chk({tag, "_dn_wf"}, 64'(AluWF), 64'(0));
        if (lock_b[w]) begin
            m_lock_vld   = 1'b1;
            m_lock_owner = w;
        end else begin
            m_lock_vld = 1'b0;
            m_prio     = ~m_prio;
        end
        @(posedge Clock); #1;
        chk({tag, "_done_end"}, 64'(Done), 64'(0));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic w0, w;
        logic [1:0] eg, ed;
        int dcount;
        Reset = 1'b0; Req = 2'b00; lock_b = 2'b00; ReqWF = 2'b00;
        ReqA0 = '0; ReqB0 = '0; ReqA1 = '0; ReqB1 = '0;
        ReqFunSel0 = '0; ReqFunSel1 = '0;
        repeat (2) @(negedge Clock);
        #1;
        chk("rst_gnt", 64'(Gnt), 64'(0));
        chk("rst_done", 64'(Done), 64'(0));
        chk("rst_res", 64'(Result), 64'(0));
        chk("rst_a", 64'(AluA), 64'(0));
        chk("rst_b", 64'(AluB), 64'(0));
        chk("rst_fs", 64'(AluFunSel), 64'(0));
        chk("rst_wf", 64'(AluWF), 64'(0));
        @(negedge Clock);
        Reset = 1'b1;

        // 5 + 3 on requester 0
        ReqA0 = 32'd5; ReqB0 = 32'd3; ReqFunSel0 = 5'b10100; ReqWF = 2'b01;
        run_txn(2'b01, "tp_add");
        chk("tp_add_res8", 64'(Result), 64'd8);
        chk("tp_add_flg0", 64'(Flags), 64'(4'b0000));

        // signed overflow on requester 1
        ReqA1 = 32'h7FFF_FFFF; ReqB1 = 32'd1; ReqFunSel1 = 5'b10100; ReqWF = 2'b10;
        run_txn(2'b10, "tp_ovf");
        chk("tp_ovf_res", 64'(Result), 64'h8000_0000);
        chk("tp_ovf_flg", 64'(Flags), 64'(4'b0011));

        // WF=0 leaves flags untouched
        ReqA0 = 32'd0; ReqB0 = 32'd0; ReqFunSel0 = 5'b10100; ReqWF = 2'b00;
        run_txn(2'b01, "tp_nowf");
        chk("tp_nowf_flg", 64'(Flags), 64'(4'b0011));

        // both requesting continuously: grants alternate every 3 cycles
        ReqA1 = 32'd9; ReqB1 = 32'd4; ReqFunSel1 = 5'b10110;
        @(negedge Clock);
        Req = 2'b11;
        w0 = m_prio;
        for (int k = 0; k < 9; k++) begin
            #1;
            w  = ((k / 3) % 2 == 0) ? w0 : ~w0;
            eg = (k % 3 == 0) ? (2'b01 << w) : 2'b00;
            ed = (k % 3 == 2) ? (2'b01 << w) : 2'b00;
            chk("hold_gnt", 64'(Gnt), 64'(eg));
            chk("hold_done", 64'(Done), 64'(ed));
            @(negedge Clock);
        end
        Req = 2'b00;
        m_prio = ~w0;
        @(posedge Clock); #1;

        // reset in the middle of ISSUE aborts the op; pointer returns to default
        if (m_prio == 1'b0) begin
            ReqWF = 2'b00;
            run_txn(2'b01, "pre_abort");
        end
        @(negedge Clock);
        ReqA0 = 32'hFFFF_FFFF; ReqB0 = 32'd1; ReqFunSel0 = 5'b10100; ReqWF = 2'b11;
        Req = 2'b01;
        #1;
        chk("abort_gnt", 64'(Gnt), 64'(2'b01));
        @(posedge Clock); #1;
        Req = 2'b00;
        chk("abort_wf_issue", 64'(AluWF), 64'(1));
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_wf", 64'(AluWF), 64'(0));
        chk("abort_done", 64'(Done), 64'(0));
        chk("abort_res", 64'(Result), 64'(0));
        @(negedge Clock);
        Reset = 1'b1;
        m_prio = 1'b0;
        m_lock_vld = 1'b0;
        dcount = 0;
        repeat (4) begin
            @(posedge Clock); #1;
            if (Done != 2'b00) dcount++;
        end
        chk("abort_nodone", 64'(dcount), 64'(0));
        chk("abort_flg", 64'(Flags), 64'(m_flags));
        ReqA1 = 32'd2; ReqB1 = 32'd2; ReqFunSel1 = 5'b10100; ReqWF = 2'b11;
        run_txn(2'b11, "post_abort");

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            ReqA0 = pick_val(); ReqB0 = pick_val();
            ReqA1 = pick_val(); ReqB1 = pick_val();
            ReqFunSel0 = {1'b1, 4'($urandom_range(4, 7))};
            ReqFunSel1 = {1'b1, 4'($urandom_range(4, 7))};
            ReqWF = 2'($urandom_range(0, 3));
            run_txn(2'($urandom_range(1, 3)), "rnd");
        end

`ifdef ALU_ARB_LOCK_EN
        // carry chain under lock: requester 1 is held off until lock drops
        lock_b = 2'b01;
        ReqA0 = 32'hFFFF_FFFF; ReqB0 = 32'd1; ReqFunSel0 = 5'b10100; ReqWF = 2'b11;
        ReqA1 = 32'd3; ReqB1 = 32'd3; ReqFunSel1 = 5'b10100;
        run_txn(2'b01, "lk_add");
        chk("lk_add_flg", 64'(Flags), 64'(4'b1100));
        ReqA0 = 32'd0; ReqB0 = 32'd0; ReqFunSel0 = 5'b10101;
        run_txn(2'b11, "lk_adc");
        chk("lk_adc_res", 64'(Result), 64'd1);
        lock_b = 2'b00;
        ReqFunSel0 = 5'b10100;
        run_txn(2'b11, "lk_rel");
        run_txn(2'b11, "lk_after");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester scheduler that shares the single `ArithmeticLogicUnit` instance between two clients, for example the control unit and an address-generation path. It arbitrates round-robin, captures the winning operands, issues exactly one ALU operation, and returns the result and flags with a done pulse. The block sits between the requesters and the ALU and is the only driver of the ALU's A, B, FunSel and WF inputs.

## Interface
Parameters:
- `DEFAULT_PRIO`, default 0: index of the requester favoured first after reset (0 or 1).

Ports:
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Req[1:0]`  in  2  per-requester request level; held until that requester sees its grant.
- `ReqA0`, `ReqB0`, `ReqA1`, `ReqB1`  in  32 each  operands for requesters 0 and 1.
- `ReqFunSel0`, `ReqFunSel1`  in  5 each  ALU function select, same encoding as the ALU.
- `ReqWF[1:0]`  in  2  per-requester write-flags enable.
- `Lock[1:0]`  in  2  keep-grant request; this port exists only when `ALU_ARB_LOCK_EN` is defined.
- `Gnt[1:0]`  out  2  one-hot grant; asserted for one cycle, in the IDLE cycle in which the request is accepted.
- `Done[1:0]`  out  2  one-hot, one-cycle pulse marking the result as valid.
- `Result`  out  32  captured ALU output.
- `Flags`  out  4  {Z, C, N, O}; passthrough of `AluFlags`.
- `AluA`, `AluB`  out  32 each  operands to the ALU.
- `AluFunSel`  out  5  function select to the ALU.
- `AluWF`  out  1  write-flags enable to the ALU.
- `AluOut`  in  32  ALU result (combinational).
- `AluFlags`  in  4  ALU registered flags.

## Operation
- The state machine has three states: IDLE, ISSUE and DONE.
- **IDLE**
  - If any `Req` bit is high, select a winner and assert its `Gnt` combinationally.
  - At the clock edge, latch the winner's operands, FunSel and WF, record the winner index, and move to ISSUE.
  - If no request is present, stay in IDLE.
- **Winner selection**
  - If only one requester is active, it wins.
  - If both are active, the requester indicated by the priority pointer `prio` wins.
  - `prio` flips to the other requester at the DONE→IDLE transition.
  - `prio` resets to `DEFAULT_PRIO`.
- **ISSUE**
  - Drive `AluA`, `AluB` and `AluFunSel` from the latched values, and drive `AluWF` from the latched WF.
  - At the clock edge, latch `Result <= AluOut`; the ALU updates its flags on the same edge. Move to DONE.
- **DONE**
  - Assert `Done[winner]` for one cycle; `Flags` reflects the updated ALU flags.
  - Move to IDLE. No request is accepted in DONE.
- **Outside ISSUE**
  - `AluWF` is held at 0, and `AluA`, `AluB` and `AluFunSel` hold their last latched values, so the flags cannot change between operations.
- `Result` holds its value until the next ISSUE edge.
- If `ReqWF` is 0, `Flags` in DONE equals the flags from before the operation.
- The block never alters the ALU's width or opcode semantics. FunSel[4] and the carry-in of ADC/CSL/CSR operations pass through unchanged, and the carry-in is the shared ALU C flag.

## Timing
- Accepted request to Done: 2 cycles, with the grant in cycle 0, ISSUE in cycle 1 and Done in cycle 2.
- Throughput is one operation per 3 cycles.
- Reset values: state=IDLE, `prio`=`DEFAULT_PRIO`, `Gnt`=0, `Done`=0, `Result`=0, `AluA`=0, `AluB`=0, `AluFunSel`=0, `AluWF`=0.
- Reset asserted mid-operation (in ISSUE or DONE) forces IDLE immediately and drops `AluWF` and `Done` asynchronously. No Done is ever issued for the aborted operation.
- If `Req` deasserts in the same cycle as the grant, the operation still completes; the grant is final.
- A requester that holds `Req` high after its Done is treated as a new request on the next IDLE cycle.

## Configuration
- `ALU_ARB_LOCK_EN` defined:
  - The `Lock` ports are present.
  - If the requester served in DONE has `Lock` high in that cycle, `prio` does not flip.
  - In the following IDLE, that requester wins whenever its `Req` is high, even against the other requester.
  - The lock persists until the owning requester deasserts `Lock` in a DONE cycle. This guarantees carry-chained multiword ADC/CSL sequences are not interleaved.
- `ALU_ARB_LOCK_EN` undefined: the `Lock` ports are absent and arbitration is purely round-robin.

## Structure
- Package `alu_arb_pkg` holds:
  - the state typedef (IDLE, ISSUE, DONE);
  - the requester-index typedef;
  - constants for carry-consuming FunSel low nibbles (0101, 1110, 1111), used by assertions.
- Sub-module `alu_arb_rr2` is the two-way round-robin pick logic, combinational, with inputs `Req`, `prio`, and the lock owner/valid.

## Test plan
- Req0, A=5, B=3, FunSel=5'b10100, WF=1 → `Gnt[0]` in cycle 0, `AluFunSel`=10100 with `AluWF`=1 in cycle 1, `Done[0]` in cycle 2 with `Result`=8 and `Flags`=4'b0000.
- Both requesting continuously → grants alternate 0,1,0,1 with `DEFAULT_PRIO`=0, and each Done follows its own grant by 2 cycles.
- Req1, A=0x7FFFFFFF, B=1, FunSel=5'b10100 → `Result`=0x80000000, `Flags`=4'b0011 (N=1, O=1).
- Req0 with WF=0 after a flag-setting operation → `Flags` in DONE are unchanged, and `AluWF` stays 0 throughout.
- Reset pulsed low during ISSUE → no Done pulse, `AluWF`=0 immediately, and the next request is granted normally with `prio`=`DEFAULT_PRIO`.
- With `ALU_ARB_LOCK_EN`: Req0 with Lock=1 issues 0xFFFFFFFF+0x00000001 (FunSel 10100), then 0+0 ADC (FunSel 10101) while Req1 is pending → the ADC `Result`=1, and `Gnt[1]` is withheld until Req0 drops `Lock`.
